// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared types and constants for the fully connected neuron
//            scheduler (accumulator type, saturation limits, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int ACC_W = 48;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Saturation limits of the signed 48-bit accumulator
    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        POST   = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fc_post_proc.sv
`default_nettype none
// ============================================================================
// Module   : fc_post_proc
// Purpose  : Combinational bias add with saturation to the 48-bit signed
//            range, followed by optional ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module fc_post_proc
    import fc_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  acc_t i_acc,
    input  acc_t i_bias,
    output acc_t o_result
);

    logic [ACC_W:0] w_sum;
    acc_t           w_sat;

    // Add at 49 bits so nothing wraps, clamp on overflow, then optionally zero negatives
    always_comb begin
        w_sum = {i_acc[ACC_W-1], i_acc} + {i_bias[ACC_W-1], i_bias};
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            // Extra sign bit disagrees with the 48-bit sign: result is out of range
            w_sat = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            w_sat = w_sum[ACC_W-1:0];
        end
        o_result = w_sat;
        if (RELU_EN && w_sat[ACC_W-1]) begin
            o_result = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_neuron_scheduler
// Purpose  : Time-shares one dot-product engine across N_OUT neurons: launch,
//            wait for the sum, add bias / saturate / ReLU, stream the result
//            out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fc_neuron_scheduler
    import fc_pkg::*;
#(
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 1024,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic                             i_abort,
    // One 48-bit two's-complement bias per neuron, neuron k in slice [k]
    input  logic [N_OUT-1:0][ACC_W-1:0]      i_bias,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    output logic                             eng_start,
    output logic [$clog2(N_OUT)-1:0]         eng_sel,
    input  logic                             eng_result_valid,
    input  acc_t                             eng_result,
    output logic                             o_valid,
    input  logic                             i_ready,
    output acc_t                             o_data,
    output logic [$clog2(N_OUT)-1:0]         o_idx
);

    localparam int IW = $clog2(N_OUT);
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t   state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  out_idx_q, out_idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    acc_t           cap_q, cap_d;
    acc_t           data_q, data_d;
    logic           err_q, err_d;
    logic           start_d1_q, start_d1_d;

    logic           w_start_pulse;
    acc_t           w_bias_sel;
    acc_t           w_post_result;

    assign w_start_pulse = i_start & ~start_d1_q;
    assign w_bias_sel    = acc_t'(i_bias[idx_q]);

    fc_post_proc #(
        .RELU_EN (RELU_EN)
    ) u_post_proc (
        .i_acc    (cap_q),
        .i_bias   (w_bias_sel),
        .o_result (w_post_result)
    );

    // State and datapath registers; reset returns everything to the idle state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_idx_q  <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            start_d1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            data_q     <= data_d;
            err_q      <= err_d;
            start_d1_q <= start_d1_d;
        end
    end

    // Next-state and Moore outputs; abort overrides every transition and strobe
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        data_d     = data_q;
        err_d      = err_q;
        start_d1_d = i_start;

        o_busy    = (state_q != IDLE);
        eng_start = (state_q == LAUNCH) && !i_abort;
        o_valid   = (state_q == EMIT)   && !i_abort;
        o_done    = (state_q == DONE)   && !i_abort;

        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_start_pulse) begin
                        err_d   = 1'b0;
                        idx_d   = '0;
                        state_d = LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (eng_result_valid) begin
                        cap_d   = eng_result;
                        state_d = POST;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                POST: begin
                    data_d    = w_post_result;
                    out_idx_d = idx_q;
                    state_d   = EMIT;
                end
                EMIT: begin
                    if (i_ready) begin
                        if (idx_q == IW'(N_OUT - 1)) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LAUNCH;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign eng_sel = idx_q;
    assign o_idx   = out_idx_q;
    assign o_data  = data_q;
    assign o_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_neuron_scheduler
// Purpose  : Self-checking bench for fc_neuron_scheduler. Two instances share
//            all inputs, one with ReLU and one without; results are compared
//            against an arithmetic reference of bias add, clamp and ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_neuron_scheduler;

    localparam int N  = 4;
    localparam int TO = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start, i_abort, i_ready, eng_result_valid;
    logic [N-1:0][47:0] i_bias;
    logic [47:0]       eng_result;

    logic        o_busy_a, o_done_a, o_error_a, eng_start_a, o_valid_a;
    logic [1:0]  eng_sel_a, o_idx_a;
    logic [47:0] o_data_a;
    logic        o_busy_b, o_done_b, o_error_b, eng_start_b, o_valid_b;
    logic [1:0]  eng_sel_b, o_idx_b;
    logic [47:0] o_data_b;

    int     vectors     = 0;
    int     miscompares = 0;
    longint eng_val [N];
    longint bias_v  [N];
    int     lat     [N];

    always #5 clk = ~clk;

    fc_neuron_scheduler #(.N_OUT(N), .TIMEOUT(TO), .RELU_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_bias(i_bias),
        .o_busy(o_busy_a), .o_done(o_done_a), .o_error(o_error_a),
        .eng_start(eng_start_a), .eng_sel(eng_sel_a),
        .eng_result_valid(eng_result_valid), .eng_result(eng_result),
        .o_valid(o_valid_a), .i_ready(i_ready), .o_data(o_data_a), .o_idx(o_idx_a)
    );

    fc_neuron_scheduler #(.N_OUT(N), .TIMEOUT(TO), .RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_bias(i_bias),
        .o_busy(o_busy_b), .o_done(o_done_b), .o_error(o_error_b),
        .eng_start(eng_start_b), .eng_sel(eng_sel_b),
        .eng_result_valid(eng_result_valid), .eng_result(eng_result),
        .o_valid(o_valid_b), .i_ready(i_ready), .o_data(o_data_b), .o_idx(o_idx_b)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact sum, clamp to the signed 48-bit range, optional ReLU
    function automatic longint ref_post(input longint acc, input longint b, input bit relu);
        longint s;
        longint mx;
        longint mn;
        mx = (longint'(1) <<< 47) - 1;
        mn = -(longint'(1) <<< 47);
        s  = acc + b;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic longint rnd48();
        longint v;
        case ($urandom_range(0, 3))
            0:       v = longint'($urandom_range(0, 2000)) - 1000;
            1:       v = (longint'(1) <<< 47) - 1 - longint'($urandom_range(0, 50));
            2:       v = -(longint'(1) <<< 47) + longint'($urandom_range(0, 50));
            default: begin v = {$urandom, $urandom}; v = v >>> 16; end
        endcase
        return v;
    endfunction

    task automatic load_bias();
        for (int k = 0; k < N; k++) i_bias[k] = bias_v[k][47:0];
    endtask

    // One run: caller leaves i_start low for at least one cycle beforehand
    task automatic run(input int bp_neuron, input int bp_cycles, input int abort_neuron,
                       input bit toggle_start);
        int g;
        load_bias();
        i_start = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            g = 0;
            while (!eng_start_a && g < 16) begin step(); g++; end
            chk("eng_start", eng_start_a, 1);
            chk("eng_sel", eng_sel_a, k);
            chk("busy", o_busy_a, 1);
            if (k == 0) chk("err_clear", o_error_a, 0);
            if (toggle_start && k == 1) i_start = 1'b0;
            if (toggle_start && k == 2) i_start = 1'b1;
            if (k == abort_neuron) begin
                step(); step();
                i_abort = 1'b1;
                step();
                i_abort = 1'b0;
                chk("abort_idle", {o_busy_a, o_valid_a, o_done_a, eng_start_a}, 0);
                eng_result_valid = 1'b1;
                eng_result       = eng_val[k][47:0];
                step();
                eng_result_valid = 1'b0;
                i_start          = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    chk("late_ignored", {o_busy_a, o_valid_a, eng_start_a}, 0);
                    step();
                end
                return;
            end
            for (int c = 0; c < lat[k]; c++) step();
            chk("one_pulse", eng_start_a, 0);
            eng_result_valid = 1'b1;
            eng_result       = eng_val[k][47:0];
            step();
            eng_result_valid = 1'b0;
            g = 0;
            while (!o_valid_a && g < 8) begin step(); g++; end
            chk("o_valid", o_valid_a, 1);
            chk("o_idx", o_idx_a, k);
            chk("o_data_relu", $signed(o_data_a), ref_post(eng_val[k], bias_v[k], 1'b1));
            chk("o_data_lin", $signed(o_data_b), ref_post(eng_val[k], bias_v[k], 1'b0));
            if (k == bp_neuron) begin
                for (int c = 0; c < bp_cycles; c++) begin
                    step();
                    chk("bp_ctrl", {o_valid_a, o_idx_a, eng_start_a}, {1'b1, k[1:0], 1'b0});
                    chk("bp_data", $signed(o_data_a), ref_post(eng_val[k], bias_v[k], 1'b1));
                end
            end
            i_ready = 1'b1;
            step();
            i_ready = 1'b0;
            chk("valid_drop", o_valid_a, 0);
        end
        chk("o_done", o_done_a, 1);
        step();
        chk("done_pulse", {o_done_a, o_busy_a}, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("no_rerun", {o_busy_a, eng_start_a, o_error_a}, 0);
        end
        i_start = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
        eng_result_valid = 1'b0; eng_result = '0; i_bias = '0;
        step(); step();
        chk("rst_ctrl_a", {o_busy_a, o_done_a, o_error_a, eng_start_a, o_valid_a, eng_sel_a, o_idx_a}, 0);
        chk("rst_ctrl_b", {o_busy_b, o_done_b, o_error_b, eng_start_b, o_valid_b, eng_sel_b, o_idx_b}, 0);
        chk("rst_data", {o_data_a, o_data_b}, 0);
        rst = 1'b0;
        step();

        // Basic run: 100, -50, 7, 0 with bias 10 after 230 cycles
        eng_val[0] = 100; eng_val[1] = -50; eng_val[2] = 7; eng_val[3] = 0;
        for (int k = 0; k < N; k++) begin bias_v[k] = 10; lat[k] = 230; end
        run(-1, 0, -1, 1'b0);

        // Saturation at both ends, with backpressure on neuron 1
        eng_val[0] = (longint'(1) <<< 47) - 1;  bias_v[0] = 5;
        eng_val[1] = -(longint'(1) <<< 47);     bias_v[1] = -1;
        eng_val[2] = rnd48();                   bias_v[2] = rnd48();
        eng_val[3] = rnd48();                   bias_v[3] = rnd48();
        for (int k = 0; k < N; k++) lat[k] = $urandom_range(1, 40);
        run(1, 20, -1, 1'b0);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                eng_val[k] = rnd48();
                bias_v[k]  = rnd48();
                lat[k]     = $urandom_range(1, 40);
            end
            run($urandom_range(0, 3), $urandom_range(0, 5), -1, 1'(r % 2));
        end

        // Timeout: engine never answers
        load_bias();
        i_start = 1'b1;
        step();
        chk("to_launch", eng_start_a, 1);
        for (int c = 0; c < TO; c++) step();
        chk("to_not_yet", {o_error_a, o_busy_a}, 1);
        step();
        chk("to_error", {o_error_a, o_busy_a, o_done_a}, 4);
        i_start = 1'b0;
        step();
        chk("to_sticky", o_error_a, 1);
        for (int k = 0; k < N; k++) begin eng_val[k] = rnd48(); lat[k] = $urandom_range(1, 20); end
        run(-1, 0, -1, 1'b0);

        // Abort during WAIT of neuron 2, then a fresh run from neuron 0
        run(-1, 0, 2, 1'b0);
        run(-1, 0, -1, 1'b0);

        // Abort and start edge in the same idle cycle: abort wins
        i_start = 1'b1; i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_vs_start", {o_busy_a, eng_start_a}, 0);
        step();
        chk("abort_no_late_start", {o_busy_a, eng_start_a}, 0);
        i_start = 1'b0;
        step();

        // Reset in the middle of a run
        i_start = 1'b1;
        step();
        chk("mid_launch", eng_start_a, 1);
        step(); step();
        rst = 1'b1; i_start = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_ctrl", {o_busy_a, o_done_a, o_error_a, eng_start_a, o_valid_a, eng_sel_a, o_idx_a}, 0);
        chk("mid_rst_data", o_data_a, 0);
        step();
        chk("mid_rst_idle", o_busy_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
